scancode_sequencer: RTL

Sits between the PS/2 byte receiver and the scan-code-to-ASCII converter. It parses the raw byte stream (make, break prefix F0, extended prefix E0), issues one converter strobe per completed code, and captures each resulting ASCII character into a small FIFO. The POV text/display logic drains that FIFO with a read handshake.

---
 rtl/scancode_sequencer_pkg.sv | 24 ++
 rtl/scancode_sequencer_char_fifo.sv | 78 +++++++
 rtl/scancode_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/scancode_sequencer_pkg.sv
// ============================================================================
// scancode_sequencer_pkg : scan-code constants and sequencer state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package scancode_sequencer_pkg;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_NONE    = 8'h00;
  localparam logic [6:0] ASCII_NONE = 7'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BRK     = 3'd1,
    ST_EXT     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_ISSUE   = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/scancode_sequencer_char_fifo.sv
// ============================================================================
// char_fifo : show-ahead circular character FIFO with sticky overflow flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module char_fifo
  import scancode_sequencer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [6:0]             din,
  input  logic                   pop_req,
  output logic [6:0]             dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   overflow_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;

  assign full  = (count == COUNT_FULL);
  assign valid = (count != '0);
  assign pop   = pop_req && valid;
  // A pop in the same cycle frees the slot, so a push while full is accepted.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign dout  = valid ? mem[rd_ptr] : ASCII_NONE;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/scancode_sequencer.sv
// ============================================================================
// scancode_sequencer : PS/2 byte-stream parser driving the ASCII converter
// Revision: 1.0
// ============================================================================
`default_nettype none

module scancode_sequencer
  import scancode_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [7:0]                  ByteIn,
  input  logic                        ByteValid,
  output logic [7:0]                  ConvActual,
  output logic [7:0]                  ConvAnterior,
  output logic                        ConvScanCodeType,
  input  logic [6:0]                  ConvAscii,
  input  logic                        ConvNewAscii,
  output logic [6:0]                  CharOut,
  output logic                        CharValid,
  input  logic                        CharRead,
  output logic [$clog2(FIFO_DEPTH):0] Count,
  output logic                        Overflow,
  input  logic                        OverflowClear,
  output logic                        Busy
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  seq_state_t      state;
  seq_state_t      state_nxt;
  logic [7:0]      hold;
  logic            hold_full;
  logic [TO_W-1:0] to_cnt;
  logic            byte_evt;
  logic [7:0]      cur_byte;
  logic            load_conv;
  logic [7:0]      ant_nxt;
  logic            waiting;
  logic            timeout;
  logic            push;

  // The held byte always precedes any fresh byte in arrival order.
  assign byte_evt = (state != ST_ISSUE) && (hold_full || ByteValid);
  assign cur_byte = hold_full ? hold : ByteIn;
  assign waiting  = (state == ST_BRK) || (state == ST_EXT) || (state == ST_EXT_BRK);
  assign timeout  = waiting && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    load_conv = 1'b0;
    ant_nxt   = SC_NONE;
    unique case (state)
      ST_IDLE, ST_BRK: begin
        // A prefix seen in BRK is a protocol error: restart as if from IDLE.
        if (byte_evt) begin
          if (cur_byte == SC_BREAK) begin
            state_nxt = ST_BRK;
          end else if (cur_byte == SC_EXT) begin
            state_nxt = ST_EXT;
          end else begin
            state_nxt = ST_ISSUE;
            load_conv = 1'b1;
            ant_nxt   = (state == ST_BRK) ? SC_BREAK : SC_NONE;
          end
        end else if (timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_EXT: begin
        if (byte_evt) begin
          state_nxt = (cur_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        end else if (timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_EXT_BRK: begin
        if (byte_evt || timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= ST_IDLE;
      ConvActual   <= SC_NONE;
      ConvAnterior <= SC_NONE;
      hold         <= SC_NONE;
      hold_full    <= 1'b0;
      to_cnt       <= '0;
    end else begin
      state <= state_nxt;
      if (load_conv) begin
        ConvActual   <= cur_byte;
        ConvAnterior <= ant_nxt;
      end
      if (state == ST_ISSUE) begin
        if (ByteValid) begin
          hold      <= ByteIn;
          hold_full <= 1'b1;
        end
      end else if (hold_full) begin
        // Held byte is consumed this cycle; a simultaneous new byte takes its place.
        if (ByteValid) begin
          hold <= ByteIn;
        end else begin
          hold_full <= 1'b0;
        end
      end
      if (!waiting || byte_evt || (state_nxt != state)) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  assign ConvScanCodeType = (state == ST_ISSUE);
  assign push             = ConvScanCodeType && ConvNewAscii && (ConvAscii != ASCII_NONE);
  assign Busy             = (state != ST_IDLE) || hold_full;

  char_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_char_fifo (
    .clk            (Clock),
    .rst            (Reset),
    .push           (push),
    .din            (ConvAscii),
    .pop_req        (CharRead),
    .dout           (CharOut),
    .valid          (CharValid),
    .count          (Count),
    .overflow       (Overflow),
    .overflow_clear (OverflowClear)
  );

endmodule

`default_nettype wire
